// File: rtl/alu_issue_pkg.sv
// Shared RV32I decode constants, ALU op codes and issue-sequencer state type.
// Imported by the ALU-facing issue logic and its decoder.
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB
  } state_e;

  // alt selects SUB/SRA for the funct3 codes that have an alternate form.
  function automatic alu_op_e funct3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP/OP-IMM decoder: register fields, ALU op,
// operand-B source, immediate and illegal-instruction flag.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [3:0]  op,
  output logic        use_imm,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode   = instr[6:0];
  assign rd_addr  = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign funct7   = instr[31:25];

  always_comb begin
    op      = ALU_ADD;
    use_imm = 1'b0;
    imm     = {{20{instr[31]}}, instr[31:20]};
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        op = funct3_to_op(funct3, funct7[5]);
        if (!((funct7 == F7_ZERO) ||
              ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
          illegal = 1'b1;
      end
      OPC_OPIMM: begin
        use_imm = 1'b1;
        case (funct3)
          3'b001: begin
            op      = ALU_SLL;
            imm     = {27'b0, instr[24:20]};
            illegal = (funct7 != F7_ZERO);
          end
          3'b101: begin
            imm = {27'b0, instr[24:20]};
            if (funct7 == F7_ZERO)     op = ALU_SRL;
            else if (funct7 == F7_ALT) op = ALU_SRA;
            else                       illegal = 1'b1;
          end
          // No SUBI: the immediate's top bit is data, never an op selector.
          default: op = funct3_to_op(funct3, 1'b0);
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue and writeback sequencer for the registered ALU:
// IDLE accepts and latches operands, EXEC waits on the ALU, WB writes rd.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  state_e          state_q, state_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [4:0]      rd_q, rd_d;
  logic            illegal_q, illegal_d;

  logic [4:0]  dec_rd;
  logic [3:0]  dec_op;
  logic        dec_use_imm;
  logic [31:0] dec_imm;
  logic        dec_illegal;

  alu_issue_decode u_decode (
    .instr    (instr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_addr  (dec_rd),
    .op       (dec_op),
    .use_imm  (dec_use_imm),
    .imm      (dec_imm),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    rd_d      = rd_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          if (dec_illegal) begin
            illegal_d = 1'b1;
          end else begin
            alu_op_d = dec_op;
            alu_a_d  = rs1_data;
            alu_b_d  = dec_use_imm ? dec_imm : rs2_data;
            rd_d     = dec_rd;
            state_d  = ST_EXEC;
          end
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign illegal     = illegal_q;

  // The ALU result only settles after the edge that enters WB, so writeback
  // is decoded from state rather than registered; reset clears it at once.
  assign wb_we   = (state_q == ST_WB) && (rd_q != 5'd0);
  assign wb_addr = rd_q;
  assign wb_data = (state_q == ST_WB) ? alu_result : '0;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural registered ALU, per-scenario
// tasks with inline checks, and a writeback scoreboard fed at issue time.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_result;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;
  wb_t sb[$];

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .illegal     (illegal)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return {31'b0, $signed(a) < $signed(b)};
      4'd4:    return {31'b0, a < b};
      4'd5:    return a ^ b;
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return a | b;
      4'd9:    return a & b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Registered ALU: result valid one clock after operands are applied.
  always @(posedge clk) alu_result <= alu_f(alu_op, alu_a, alu_b);

  always @(negedge clk) begin
    if (wb_we) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_write addr=%0d data=%h expected no write", wb_addr, wb_data);
      end else begin
        wb_t e;
        e = sb.pop_front();
        if (wb_addr !== e.addr || wb_data !== e.data)
          $display("FAIL sb_write got addr=%0d data=%h exp addr=%0d data=%h",
                   wb_addr, wb_data, e.addr, e.data);
        else passed++;
      end
    end
  end

  task automatic run_instr(input string name, input logic [31:0] ins, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] eop,
                           input logic [31:0] eb, input logic [4:0] rd,
                           input logic [31:0] edata);
    if (rd != 5'd0) sb.push_back('{rd, edata});
    instr = ins; rs1_data = a; rs2_data = b; instr_valid = 1'b1;
    checks++;
    if (instr_ready !== 1'b1) $display("FAIL %s ready_before got %b exp 1", name, instr_ready);
    else passed++;
    @(posedge clk); #1;
    instr_valid = 1'b0; rs1_data = $urandom; rs2_data = $urandom;
    checks++;
    if (alu_op !== eop) $display("FAIL %s alu_op got %0d exp %0d", name, alu_op, eop);
    else passed++;
    checks++;
    if (alu_a !== a) $display("FAIL %s alu_a got %h exp %h", name, alu_a, a);
    else passed++;
    checks++;
    if (alu_b !== eb) $display("FAIL %s alu_b got %h exp %h", name, alu_b, eb);
    else passed++;
    checks++;
    if (instr_ready !== 1'b0 || wb_we !== 1'b0)
      $display("FAIL %s exec_ctrl got ready=%b we=%b exp ready=0 we=0", name, instr_ready, wb_we);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b0 || wb_we !== (rd != 5'd0) || wb_addr !== rd || wb_data !== edata)
      $display("FAIL %s wb got ready=%b we=%b addr=%0d data=%h exp ready=0 we=%b addr=%0d data=%h",
               name, instr_ready, wb_we, wb_addr, wb_data, rd != 5'd0, rd, edata);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b1 || wb_we !== 1'b0)
      $display("FAIL %s idle_after got ready=%b we=%b exp ready=1 we=0", name, instr_ready, wb_we);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wb_we !== 1'b0 || illegal !== 1'b0 || alu_op !== 4'd0 || alu_a !== 32'd0 ||
        alu_b !== 32'd0 || wb_addr !== 5'd0 || wb_data !== 32'd0)
      $display("FAIL reset_outputs got we=%b ill=%b op=%0d a=%h b=%h wa=%0d wd=%h exp all 0",
               wb_we, illegal, alu_op, alu_a, alu_b, wb_addr, wb_data);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", instr_ready);
    else passed++;
  endtask

  task automatic test_op();
    run_instr("add",  32'h002081B3, 32'h10, 32'h20, 4'd0, 32'h20, 5'd3, 32'h30);
    run_instr("sub",  32'h402081B3, 32'h30, 32'h10, 4'd1, 32'h10, 5'd3, 32'h20);
    run_instr("xor",  32'h0020C3B3, 32'hF0F0F0F0, 32'hFF00FF00, 4'd5, 32'hFF00FF00, 5'd7, 32'h0FF00FF0);
    run_instr("sltu", 32'h0020B433, 32'h1, 32'hFFFFFFFF, 4'd4, 32'hFFFFFFFF, 5'd8, 32'h1);
    run_instr("slt",  32'h0020A4B3, 32'h1, 32'hFFFFFFFF, 4'd3, 32'hFFFFFFFF, 5'd9, 32'h0);
    run_instr("srl",  32'h0020D6B3, 32'h80000000, 32'h24, 4'd6, 32'h24, 5'd13, 32'h08000000);
  endtask

  task automatic test_op_imm();
    run_instr("addi", 32'hFFF08293, 32'h5, 32'h0, 4'd0, 32'hFFFFFFFF, 5'd5, 32'h4);
    run_instr("srai", 32'h4040D313, 32'h80000000, 32'h0, 4'd7, 32'h4, 5'd6, 32'hF8000000);
    run_instr("slli", 32'h01F09513, 32'h1, 32'h0, 4'd2, 32'h1F, 5'd10, 32'h80000000);
    run_instr("andi", 32'h8000F593, 32'h12345678, 32'h0, 4'd9, 32'hFFFFF800, 5'd11, 32'h12345000);
    run_instr("ori",  32'h7FF0E613, 32'h80000000, 32'h0, 4'd8, 32'h7FF, 5'd12, 32'h800007FF);
  endtask

  task automatic test_illegal();
    logic [31:0] bad [4];
    bad[0] = 32'h0000007F;  // unknown opcode
    bad[1] = 32'h4020C3B3;  // XOR with alternate funct7
    bad[2] = 32'h41F09513;  // SLLI with alternate funct7
    bad[3] = 32'h0240D313;  // shift-right imm with funct7 0000001
    for (int i = 0; i < 4; i++) begin
      instr = bad[i]; rs1_data = 32'hAAAA5555; rs2_data = 32'h1234; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      checks++;
      if (illegal !== 1'b1 || instr_ready !== 1'b1 || wb_we !== 1'b0)
        $display("FAIL illegal_pulse[%0d] got ill=%b ready=%b we=%b exp ill=1 ready=1 we=0",
                 i, illegal, instr_ready, wb_we);
      else passed++;
      checks++;
      if (alu_op !== 4'd8 || alu_a !== 32'h80000000)
        $display("FAIL illegal_hold[%0d] got op=%0d a=%h exp op=8 a=80000000", i, alu_op, alu_a);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (illegal !== 1'b0 || instr_ready !== 1'b1)
        $display("FAIL illegal_end[%0d] got ill=%b ready=%b exp ill=0 ready=1", i, illegal, instr_ready);
      else passed++;
    end
    run_instr("add_x0", 32'h00208033, 32'h10, 32'h20, 4'd0, 32'h20, 5'd0, 32'h30);
  endtask

  task automatic test_back_to_back();
    sb.push_back('{5'd3, 32'h30});
    sb.push_back('{5'd3, 32'h20});
    instr = 32'h002081B3; rs1_data = 32'h10; rs2_data = 32'h20; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = 32'h402081B3; rs1_data = 32'h30; rs2_data = 32'h10;
    checks++;
    if (alu_op !== 4'd0 || alu_a !== 32'h10)
      $display("FAIL b2b_first got op=%0d a=%h exp op=0 a=10", alu_op, alu_a);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b0) $display("FAIL b2b_wb_ready got %b exp 0", instr_ready);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b1 || alu_op !== 4'd0)
      $display("FAIL b2b_idle got ready=%b op=%0d exp ready=1 op=0", instr_ready, alu_op);
    else passed++;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++;
    if (alu_op !== 4'd1 || alu_a !== 32'h30 || alu_b !== 32'h10 || instr_ready !== 1'b0)
      $display("FAIL b2b_second got op=%0d a=%h b=%h ready=%b exp op=1 a=30 b=10 ready=0",
               alu_op, alu_a, alu_b, instr_ready);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_exec();
    instr = 32'h002081B3; rs1_data = 32'h10; rs2_data = 32'h20; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1 || wb_we !== 1'b0 || alu_op !== 4'd0 || alu_a !== 32'd0 ||
        alu_b !== 32'd0 || wb_addr !== 5'd0 || wb_data !== 32'd0 || illegal !== 1'b0)
      $display("FAIL rst_mid got ready=%b we=%b op=%0d a=%h b=%h wa=%0d wd=%h ill=%b exp ready=1 rest 0",
               instr_ready, wb_we, alu_op, alu_a, alu_b, wb_addr, wb_data, illegal);
    else passed++;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (instr_ready !== 1'b1 || wb_we !== 1'b0)
        $display("FAIL rst_after[%0d] got ready=%b we=%b exp ready=1 we=0", i, instr_ready, wb_we);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_op();
    test_op_imm();
    test_illegal();
    test_back_to_back();
    test_reset_mid_exec();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) $display("FAIL sb_drain pending=%0d exp 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
